alu_arbiter: RTL

- Shares the single combinational ALU (alu_op_e ops, compare flags) between NUM_REQ requesters, e.g. the execute stage and the branch/address unit.
- Round-robin grant of at most one ALU operation per cycle.
- Registers each result into a one-entry per-requester response slot with valid/ready handshake.
- Sits between the issue/decode logic and the ALU instance, which it instantiates.

---
 rtl/copperv_pkg.sv | 44 ++++
 rtl/alu.sv | 40 ++++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/alu_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/copperv_pkg.sv
// Shared copperv types: ALU op codes, flag and request bundles, arbiter slot states.
package copperv_pkg;

    localparam int ALU_XLEN        = 32;
    localparam int ALU_OP_W        = 4;
    localparam int ALU_ARB_MAX_REQ = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic ltu;
        logic lt;
        logic eq;
    } alu_flags_t;

    typedef struct packed {
        alu_op_e               op;
        logic [ALU_XLEN-1:0]   din1;
        logic [ALU_XLEN-1:0]   din2;
    } alu_req_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Compare flags are only meaningful for the set-less-than ops.
    function automatic logic is_compare(alu_op_e op);
        return (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; codes outside the defined op set yield a zero result and zero flags.
module alu
    import copperv_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     din1,
    input  logic [XLEN-1:0]     din2,
    output logic [XLEN-1:0]     dout,
    output logic [2:0]          flags
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = din2[SHW-1:0];

    always_comb begin
        dout  = '0;
        flags = '0;
        case (alu_op_e'(op))
            ALU_ADD:  dout = din1 + din2;
            ALU_SUB:  dout = din1 - din2;
            ALU_AND:  dout = din1 & din2;
            ALU_OR:   dout = din1 | din2;
            ALU_XOR:  dout = din1 ^ din2;
            ALU_SLL:  dout = din1 << shamt;
            ALU_SRL:  dout = din1 >> shamt;
            ALU_SRA:  dout = $signed(din1) >>> shamt;
            ALU_SLT:  dout = XLEN'($signed(din1) < $signed(din2));
            ALU_SLTU: dout = XLEN'(din1 < din2);
            default:  dout = '0;
        endcase
        if (is_compare(alu_op_e'(op))) begin
            flags = {din1 < din2, $signed(din1) < $signed(din2), din1 == din2};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from an internal pointer that
// advances past the winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_next;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with a registered one-entry result slot each.
// Define ALU_ARBITER_PERF_EN to add per-requester stall counters on perf_stall_cnt.
module alu_arbiter
    import copperv_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = ALU_XLEN
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]   req_op,
    input  logic [NUM_REQ-1:0][XLEN-1:0]       req_din1,
    input  logic [NUM_REQ-1:0][XLEN-1:0]       req_din2,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [NUM_REQ-1:0][XLEN-1:0]       rsp_dout,
`ifdef ALU_ARBITER_PERF_EN
    output logic [NUM_REQ-1:0][15:0]           perf_stall_cnt,
`endif
    output logic [NUM_REQ-1:0][2:0]            rsp_flags
);

    // Handshake: a request transfers in the cycle req_valid[i] & req_ready[i];
    // a response transfers in the cycle rsp_valid[i] & rsp_ready[i]. A full slot
    // may take a new op in the same cycle its old result is consumed.
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    slot_state_e        slot_q [NUM_REQ];
    slot_state_e        slot_d [NUM_REQ];
    alu_req_t           alu_req;
    logic [XLEN-1:0]    alu_dout;
    logic [2:0]         alu_flags;

    always_comb begin
        eligible  = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i]  = !rst && req_valid[i] &&
                           ((slot_q[i] == SLOT_EMPTY) || rsp_ready[i]);
            rsp_valid[i] = (slot_q[i] == SLOT_FULL);
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (eligible),
        .grant (grant)
    );

    assign req_ready = grant;

    always_comb begin
        alu_req.op   = ALU_NOP;
        alu_req.din1 = '0;
        alu_req.din2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_req.op   = alu_op_e'(req_op[i]);
                alu_req.din1 = req_din1[i];
                alu_req.din2 = req_din2[i];
            end
        end
    end

    alu #(.XLEN(XLEN)) u_alu (
        .op    (alu_req.op),
        .din1  (alu_req.din1),
        .din2  (alu_req.din2),
        .dout  (alu_dout),
        .flags (alu_flags)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_d[i] = slot_q[i];
            if (grant[i])          slot_d[i] = SLOT_FULL;
            else if (rsp_ready[i]) slot_d[i] = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= SLOT_EMPTY;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= slot_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_dout  <= '0;
            rsp_flags <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    rsp_dout[i]  <= alu_dout;
                    rsp_flags[i] <= alu_flags;
                end
            end
        end
    end

`ifdef ALU_ARBITER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_ready[i] && (perf_stall_cnt[i] != 16'hFFFF))
                    perf_stall_cnt[i] <= perf_stall_cnt[i] + 16'd1;
            end
        end
    end
`endif

endmodule
